// File: rtl/rc_as_seq32_if.sv
// Operand/result bundle for the byte-serial 32-bit add/sub sequencer.
// The master drives the request, the slave returns status and result.
interface rc_as_seq32_if;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
    logic        ovf;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/rc_as_seq32.sv
// Byte-serial 32-bit adder/subtractor built around one 8-bit
// ripple-carry add/sub slice, LSB byte first, one byte per clock.
module rc_as8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;
    logic [7:0] bx;

    assign c[0] = cin;
    assign bx   = b ^ {8{sub}};

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]  = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign cout = c[8];
endmodule

module rc_as_seq32 (
    input  logic        clk,
    input  logic        rst,
    rc_as_seq32_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  idx_q;
    logic        carry_q;
    logic        op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic        cout_q;
    logic        ovf_q;
    logic        busy_c;
    logic        done_c;

    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [7:0]  b_eff;
    logic [7:0]  sum;
    logic        sum_cout;
    logic        last;

    assign a_byte = a_q[{idx_q, 3'b000} +: 8];
    assign b_byte = b_q[{idx_q, 3'b000} +: 8];
    // Subtraction is a + ~b + 1; the +1 comes from the preloaded carry.
    assign b_eff  = op_q ? ~b_byte : b_byte;
    assign last   = (idx_q == 2'd3);

    rc_as8 u_rc_as (
        .a    (a_byte),
        .b    (b_eff),
        .cin  (carry_q),
        .sub  (1'b0),
        .sum  (sum),
        .cout (sum_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                busy_c = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= 2'd0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a_in;
                        b_q     <= bus.b_in;
                        op_q    <= bus.op;
                        carry_q <= bus.op;
                        idx_q   <= 2'd0;
                    end
                end
                CALC: begin
                    result_q[{idx_q, 3'b000} +: 8] <= sum;
                    carry_q <= sum_cout;
                    idx_q   <= idx_q + 2'd1;
                    // Top byte: a[31] is a_byte[7], effective b[31] is b_eff[7].
                    if (last) begin
                        cout_q <= sum_cout;
                        ovf_q  <= (a_byte[7] == b_eff[7]) &&
                                  (sum[7] != a_byte[7]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_rc_as_seq32.sv
// Directed bench for rc_as_seq32: vector table plus hand-built
// sequences for start-during-CALC and reset-abort.
module tb_rc_as_seq32;
    logic clk;
    logic rst;

    rc_as_seq32_if bus ();

    rc_as_seq32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after edge k+5,
    // so a following call is accepted at edge k+6.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int pulses;
        rst        = 1'b0;
        bus.start  = 1'b1;
        bus.a_in   = v.a;
        bus.b_in   = v.b;
        bus.op     = v.op;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.a_in   = ~v.a;
        bus.b_in   = ~v.b;
        bus.op     = ~v.op;
        lat        = 0;
        pulses     = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
            if (n == 6) check({tag, " idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
            if (bus.done) begin
                pulses++;
                if (lat == 0) begin
                    lat = n;
                    check({tag, " result"}, bus.result, v.res);
                    check({tag, " cout"}, {31'd0, bus.cout}, {31'd0, v.cout});
                    check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, v.ovf});
                end
            end
        end
        check({tag, " latency"}, lat, 32'd5);
        check({tag, " pulses"}, pulses, 32'd1);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{32'h00000003, 32'h00000001, 1'b0, 32'h00000004, 1'b0, 1'b0};
        vecs[1] = '{32'h00000003, 32'h00000001, 1'b1, 32'h00000002, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[3] = '{32'h00000001, 32'h00000002, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0};
        vecs[7] = '{32'h10000000, 32'h00000001, 1'b1, 32'h0FFFFFFF, 1'b1, 1'b0};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[9] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = 32'd0;
        bus.b_in  = 32'd0;
        repeat (2) @(negedge clk);
        check("reset result", bus.result, 32'd0);
        check("reset flags",
              {28'd0, bus.busy, bus.done, bus.cout, bus.ovf}, 32'd0);

        // First call releases reset with start already high.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Second start with other operands during CALC must be ignored.
        bus.start = 1'b1;
        bus.a_in  = 32'h00000003;
        bus.b_in  = 32'h00000001;
        bus.op    = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 2) begin
                bus.start = 1'b1;
                bus.a_in  = 32'h00000100;
                bus.b_in  = 32'h00000200;
                bus.op    = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                pulses++;
                check("ignore result", bus.result, 32'h00000004);
            end
        end
        check("ignore pulses", pulses, 32'd1);
        check("ignore held", bus.result, 32'h00000004);

        // Reset after edge k+2 aborts mid-calculation.
        bus.start = 1'b1;
        bus.a_in  = 32'h01020304;
        bus.b_in  = 32'h10101010;
        bus.op    = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort result", bus.result, 32'd0);
        check("abort flags",
              {28'd0, bus.busy, bus.done, bus.cout, bus.ovf}, 32'd0);
        pulses = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort no done", pulses, 32'd0);
        run_op('{32'h01020304, 32'h10101010, 1'b0, 32'h11121314, 1'b0, 1'b0},
               "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rc_as_seq32.md
RC_AS_SEQ32 -- requirements
Module: rc_as_seq32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin one operation; sampled on rising clk.
REQ-005 op  input  1  operation select: 0 = add (a_in+b_in), 1 = subtract (a_in-b_in).
REQ-006 a_in  input  32  first operand; sampled only when start is accepted.
REQ-007 b_in  input  32  second operand; sampled only when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress (CALC or DONE state).
REQ-009 done  output  1  one-cycle pulse; result, cout and ovf are valid while it is high.
REQ-010 result  output  32  32-bit sum/difference, held until the next accepted start.
REQ-011 cout  output  1  raw carry out of bit 31 (sub: 1 = no borrow), held with result.
REQ-012 ovf  output  1  two's-complement signed overflow flag, held with result.

Function
REQ-013 The block SHALL contain exactly one 8-bit ripple-carry adder/subtractor (RC_AS) instance and SHALL compute the 32-bit result byte-serially, LSB byte first.
REQ-014 The RC_AS instance SHALL always operate in add mode: its B input SHALL be the current b byte when op=0 and the bitwise inverse of the current b byte when op=1, and its Cin SHALL be the internal carry register.
REQ-015 On accepting start, the carry register SHALL load op (0 for add, 1 for subtract) and the byte index SHALL load 0.
REQ-016 The FSM SHALL have the states IDLE, CALC and DONE, with a 2-bit byte index (0..3) that is active in CALC.
REQ-017 In IDLE, start=1 at a rising edge SHALL latch a_in, b_in and op, and SHALL move the FSM to CALC with index 0; start=0 SHALL leave the FSM in IDLE.
REQ-018 In CALC, each rising edge SHALL write the RC_AS Sum into result byte[index], load the RC_AS Cout into the carry register, and increment the index.
REQ-019 The edge that writes byte 3 SHALL move the FSM to DONE and SHALL update cout (the byte 3 carry) and ovf.
REQ-020 ovf SHALL be 1 exactly when bit 31 of A equals bit 31 of the effective B (b for add, ~b for subtract) and bit 31 of result differs from them.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-022 Latency: if start is accepted at edge k, done SHALL be high during the cycle that follows edge k+4, and the block SHALL accept a new start at edge k+6 at the earliest.
REQ-023 start SHALL be ignored in CALC and DONE: the latched operands SHALL NOT change and no second operation SHALL be queued.
REQ-024 Changes on a_in, b_in or op after acceptance SHALL NOT affect the operation in progress.
REQ-025 busy SHALL be 1 in CALC and DONE and 0 in IDLE; done SHALL be 0 outside DONE.
REQ-026 result SHALL be updated byte by byte during CALC; it SHALL be considered valid only when done=1 and thereafter until the next accepted start.
REQ-027 Carry out of bit 31 SHALL NOT wrap into byte 0; the arithmetic is modulo 2^32.

Reset
REQ-028 While rst=1, asynchronously: state = IDLE, index = 0, carry = 0, busy = 0, done = 0, result = 0, cout = 0, ovf = 0, and the latched operands = 0.
REQ-029 A reset asserted during CALC or DONE SHALL abort the operation with no done pulse; after reset release the block SHALL be in IDLE and accept a new start.
REQ-030 A start that is high on the first edge after reset release SHALL be accepted normally.

Verification
REQ-031 add: a=0x00000003, b=0x00000001, op=0 -> result=0x00000004, cout=0, ovf=0; done high in the cycle after edge k+4.
REQ-032 sub: a=0x00000003, b=0x00000001, op=1 -> result=0x00000002, cout=1, ovf=0.
REQ-033 full carry chain: a=0xFFFFFFFF, b=0x00000001, op=0 -> result=0x00000000, cout=1, ovf=0; borrow: a=1, b=2, op=1 -> result=0xFFFFFFFF, cout=0, ovf=0.
REQ-034 signed overflow: a=0x7FFFFFFF, b=1, op=0 -> result=0x80000000, ovf=1, cout=0; a=0x80000000, b=1, op=1 -> result=0x7FFFFFFF, ovf=1, cout=1.
REQ-035 start pulsed with different operands during CALC -> ignored; exactly one done pulse with the first operation's result.
REQ-036 rst asserted after edge k+2 -> all outputs 0 immediately, no done pulse; a fresh start then yields a correct result.
